// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC select, fetch handshake,
// run/halt/fault control and retired-instruction counting.
module pc_sequencer #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      pc_selection,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] alu_result,
   input  logic            fetch_ack,
   input  logic            stall,
   input  logic            resume,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            fetch_req,
   output logic            halted,
   output logic            fault,
   output logic [XLEN-1:0] fault_pc,
   output logic [31:0]     instret
);

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_HALT,
      S_FAULT
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] fault_pc_q, fault_pc_d;
   logic [31:0]     instret_q, instret_d;
   logic            fetch_req_q, halted_q, fault_q;

   logic            commit;
   logic            xfer;
   logic [XLEN-1:0] target;

   assign pc_plus4 = pc_q + XLEN'(4);
   assign commit   = (state_q == S_RUN) && fetch_ack && !stall;
   assign xfer     = (pc_selection == 2'b01) || (pc_selection == 2'b10);

   always_comb begin
      target = pc_plus4;
      unique case (pc_selection)
         2'b01:   target = {alu_result[XLEN-1:1], 1'b0};
         2'b10:   target = branch_target;
         default: target = pc_plus4;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fault_pc_d = fault_pc_q;
      instret_d  = instret_q;
      unique case (state_q)
         S_BOOT: state_d = S_RUN;
         S_RUN: begin
            if (commit) begin
               // A misaligned jump target freezes the core at the offender.
               if (xfer && target[1]) begin
                  state_d    = S_FAULT;
                  fault_pc_d = pc_q;
               end else begin
                  pc_d      = target;
                  instret_d = instret_q + 32'd1;
                  if (pc_selection == 2'b11) state_d = S_HALT;
               end
            end
         end
         S_HALT: if (resume) state_d = S_RUN;
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_BOOT;
         pc_q        <= RESET_PC;
         fault_pc_q  <= '0;
         instret_q   <= '0;
         fetch_req_q <= 1'b0;
         halted_q    <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         fault_pc_q  <= fault_pc_d;
         instret_q   <= instret_d;
         fetch_req_q <= (state_d == S_RUN);
         halted_q    <= (state_d == S_HALT);
         fault_q     <= (state_d == S_FAULT);
      end
   end

   assign pc        = pc_q;
   assign fetch_req = fetch_req_q;
   assign halted    = halted_q;
   assign fault     = fault_q;
   assign fault_pc  = fault_pc_q;
   assign instret   = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer against a
// behavioural next-PC / mode model.
module tb_pc_sequencer;

   logic        clk;
   logic        rst_n;
   logic [1:0]  pc_selection;
   logic [31:0] branch_target;
   logic [31:0] alu_result;
   logic        fetch_ack;
   logic        stall;
   logic        resume;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_req;
   logic        halted;
   logic        fault;
   logic [31:0] fault_pc;
   logic [31:0] instret;

   pc_sequencer #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_selection (pc_selection),
      .branch_target(branch_target),
      .alu_result   (alu_result),
      .fetch_ack    (fetch_ack),
      .stall        (stall),
      .resume       (resume),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .fetch_req    (fetch_req),
      .halted       (halted),
      .fault        (fault),
      .fault_pc     (fault_pc),
      .instret      (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] cnt;
      logic [31:0] fpc;
      logic        fr;
      logic        h;
      logic        f;
   } exp_t;

   exp_t exp_q[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   // Model mode: 0 booting, 1 running, 2 halted, 3 faulted
   int          m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   logic [31:0] m_fpc;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t",
                    name, act, exp, $time);
   endtask

   function automatic exp_t snap();
      exp_t e;
      e.pc  = m_pc;
      e.cnt = m_cnt;
      e.fpc = m_fpc;
      e.fr  = (m_mode == 1);
      e.h   = (m_mode == 2);
      e.f   = (m_mode == 3);
      return e;
   endfunction

   function automatic void model_reset();
      m_mode = 0;
      m_pc   = 32'h0;
      m_cnt  = 32'h0;
      m_fpc  = 32'h0;
   endfunction

   function automatic void model_edge(input logic [1:0] sel,
                                      input logic [31:0] bt,
                                      input logic [31:0] alu,
                                      input logic ack, input logic stl,
                                      input logic res);
      logic [31:0] dest;
      if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (ack && !stl) begin
            if (sel == 2'd1) dest = alu - (alu % 2);
            else if (sel == 2'd2) dest = bt;
            else dest = m_pc + 32'd4;
            if ((sel == 2'd1 || sel == 2'd2) && ((dest / 2) % 2 == 1)) begin
               m_mode = 3;
               m_fpc  = m_pc;
            end else begin
               m_pc  = dest;
               m_cnt = m_cnt + 32'd1;
               if (sel == 2'd3) m_mode = 2;
            end
         end
      end else if (m_mode == 2) begin
         if (res) m_mode = 1;
      end
   endfunction

   // Called at a falling edge: drive, predict the next rising edge, advance.
   task automatic step(input logic [1:0] sel, input logic [31:0] bt,
                       input logic [31:0] alu, input logic ack,
                       input logic stl, input logic res);
      pc_selection  = sel;
      branch_target = bt;
      alu_result    = alu;
      fetch_ack     = ack;
      stall         = stl;
      resume        = res;
      model_edge(sel, bt, alu, ack, stl, res);
      exp_q.push_back(snap());
      @(negedge clk);
   endtask

   task automatic go(input logic [1:0] sel, input logic [31:0] t);
      step(sel, t, t, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic idle(input logic ack, input logic stl, input logic res);
      step(2'd0, 32'h0, 32'h0, ack, stl, res);
   endtask

   // Called at a falling edge; asserts reset asynchronously mid-cycle.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_pc", pc, 32'h0);
      chk("rst_instret", instret, 32'h0);
      chk("rst_fault_pc", fault_pc, 32'h0);
      chk("rst_flags", {29'd0, fetch_req, halted, fault}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_plus4", pc_plus4, e.pc + 32'd4);
            chk("instret", instret, e.cnt);
            chk("fault_pc", fault_pc, e.fpc);
            chk("fetch_req", {31'd0, fetch_req}, {31'd0, e.fr});
            chk("halted", {31'd0, halted}, {31'd0, e.h});
            chk("fault", {31'd0, fault}, {31'd0, e.f});
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: time limit reached, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin : driver
      logic [1:0]  sel;
      logic [31:0] bt;
      logic [31:0] alu;
      rst_n         = 1'b0;
      pc_selection  = 2'd0;
      branch_target = 32'h0;
      alu_result    = 32'h0;
      fetch_ack     = 1'b0;
      stall         = 1'b0;
      resume        = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      do_reset();

      idle(1'b0, 1'b0, 1'b0);
      repeat (3) go(2'd0, 32'h0);
      go(2'd2, 32'h10);
      go(2'd2, 32'h40);
      go(2'd1, 32'h81);
      go(2'd2, 32'h20);
      go(2'd2, 32'h22);
      idle(1'b0, 1'b0, 1'b1);
      repeat (2) idle(1'b1, 1'b0, 1'b1);
      do_reset();

      idle(1'b0, 1'b0, 1'b0);
      go(2'd2, 32'h8);
      go(2'd3, 32'h0);
      repeat (3) go(2'd0, 32'h0);
      idle(1'b0, 1'b0, 1'b1);
      go(2'd0, 32'h0);
      repeat (4) go(2'd3, 32'h0) ;
      idle(1'b0, 1'b0, 1'b1);
      repeat (4) step(2'd2, 32'h100, 32'h100, 1'b1, 1'b1, 1'b0);
      go(2'd0, 32'h0);
      go(2'd2, 32'hFFFF_FFFC);
      go(2'd0, 32'h0);
      go(2'd0, 32'h0);
      step(2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      do_reset();

      for (int i = 0; i < 3000; i++) begin
         if (m_mode == 3 && ($urandom % 6 == 0)) begin
            do_reset();
         end else begin
            sel = 2'($urandom);
            bt  = $urandom & 32'hFFFF_FFFC;
            alu = $urandom & 32'hFFFF_FFFD;
            if ($urandom % 12 == 0) bt = bt | 32'h2;
            if ($urandom % 12 == 0) alu = alu | 32'h2;
            if (sel == 2'd3 && ($urandom % 2 == 0)) sel = 2'd0;
            step(sel, bt, alu, ($urandom % 4) != 0, ($urandom % 4) == 0,
                 ($urandom % 5) == 0);
         end
      end

      @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the RV32 core. It sits directly downstream of the branch control logic and consumes its 2-bit `pc_selection` to select and register the next PC. It owns the fetch request handshake with instruction memory and the run/halt/fault state machine, which is entered on ECALL/EBREAK or on a misaligned control-transfer target. It also keeps a retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 32, datapath and PC width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_selection`  in  2  next-PC select from branch control: 00 sequential, 01 JALR (ALU result), 10 branch/JAL target, 11 ECALL/EBREAK.
- `branch_target`  in  XLEN  PC-relative target from the branch adder.
- `alu_result`  in  XLEN  JALR target (rs1 + imm).
- `fetch_ack`  in  1  instruction memory has returned the instruction at `pc` this cycle.
- `stall`  in  1  hold the current instruction; no commit this cycle.
- `resume`  in  1  single-cycle pulse that leaves HALT.
- `pc`  out  XLEN  registered current PC.
- `pc_plus4`  out  XLEN  `pc + 4`, combinational, modulo 2^XLEN.
- `fetch_req`  out  1  fetch request for the instruction at `pc`.
- `halted`  out  1  high while in HALT.
- `fault`  out  1  high while in FAULT.
- `fault_pc`  out  XLEN  PC of the instruction whose target was misaligned.
- `instret`  out  32  count of committed instructions.

## Operation
- States: BOOT, RUN, HALT, FAULT. Reset enters BOOT.
- Reset values: `pc`=RESET_PC, state=BOOT, `fetch_req`=0, `halted`=0, `fault`=0, `fault_pc`=0, `instret`=0.
- BOOT: `fetch_req`=0 for exactly one cycle, then RUN unconditionally.
- RUN: `fetch_req`=1. Commit occurs when `fetch_ack`=1 and `stall`=0. With no commit, `pc` and `instret` hold.
- Next PC on commit:
  - 00: `pc_plus4`.
  - 01: `{alu_result[XLEN-1:1],1'b0}` (bit 0 cleared per the ISA).
  - 10: `branch_target`.
  - 11: `pc_plus4`, and the state goes to HALT.
- Misaligned check: on a commit with select 01 or 10, if bit 1 of the computed target is 1, then:
  - the state goes to FAULT, `fault_pc` is loaded with `pc`, and `pc` holds;
  - `instret` does not increment.
- `instret` increments by 1 on every non-faulting commit, including select 11. It wraps from 0xFFFF_FFFF to 0.
- HALT: `fetch_req`=0 and `pc` holds. A `resume` pulse returns the state to RUN on the next edge. `fetch_ack`, `stall` and `pc_selection` are ignored.
- FAULT: `fetch_req`=0 and all state holds. Only `rst_n` exits FAULT; `resume` is ignored.
- `resume` is ignored outside HALT.
- `pc_selection` is sampled only on commit cycles. The 2'b11 code does nothing outside a commit.

## Timing
- Commit-to-update latency is 1 cycle: `pc` shows the new value on the edge after the commit cycle.
- `fetch_req` is a registered-state decode and is valid from the start of each cycle. `fetch_ack` may be asserted in the same cycle as `fetch_req`.
- Back-to-back commits are allowed, giving one instruction per cycle when `fetch_ack`=1 and `stall`=0 continuously.
- `stall` and `fetch_ack` arriving together: `stall` wins; no commit, nothing changes.
- `halted` and `fault` rise the edge after the triggering commit. `halted` falls the edge after `resume`.
- PC wrap: sequential advance from 0xFFFF_FFFC gives 0x0000_0000 with no fault.
- Asserting `rst_n` low at any point, including mid-stall, in HALT or in FAULT, clears all state immediately (asynchronously). Release follows the BOOT sequence.
- No combinational path from any input to `fetch_req`, `halted` or `fault`.

## Test plan
- Reset release, then `fetch_ack`=1 for 3 cycles with select 00 -> `fetch_req` low for 1 cycle; `pc` steps 0x0, 0x4, 0x8, 0xC; `instret`=3.
- At `pc`=0x10: select 10 with `branch_target`=0x40, then select 01 with `alu_result`=0x81 -> `pc`=0x40, then `pc`=0x80.
- At `pc`=0x20: select 10 with `branch_target`=0x22 -> `fault`=1, `fault_pc`=0x20, `pc` stays 0x20, `instret` unchanged, `fetch_req`=0; `resume` has no effect; only reset clears it.
- At `pc`=0x8: select 11 -> `halted`=1, `pc`=0xC; `fetch_ack` pulses ignored; `resume` -> RUN, next commit from 0xC.
- With `fetch_ack`=1 and `stall`=1 for 4 cycles -> `pc` and `instret` frozen; drop `stall` -> a single commit.
- Preload `pc`=0xFFFF_FFFC with select 00 -> `pc`=0x0, no fault. Also pull `rst_n` low mid-stall -> all outputs return to reset values immediately.
